// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: default geometry,
// the zero-register address and the dump walker state encoding.
package regfile_pkg;

    localparam int DEF_WIDTH    = 64;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;

    localparam logic [DEF_ADDR_W-1:0] XZR_ADDR = 5'd31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Register-file read port plus the {address, data} valid/ready output stream.
interface regfile_dump_reader_if #(
    parameter int WIDTH  = regfile_pkg::DEF_WIDTH,
    parameter int ADDR_W = regfile_pkg::DEF_ADDR_W
);
    logic [ADDR_W-1:0] rdAddr;
    logic [WIDTH-1:0]  rdData;
    logic [ADDR_W-1:0] outAddr;
    logic [WIDTH-1:0]  outData;
    logic              outValid;
    logic              outReady;

    modport master (
        output rdAddr,
        input  rdData,
        output outAddr,
        output outData,
        output outValid,
        input  outReady
    );

    modport slave (
        input  rdAddr,
        output rdData,
        input  outAddr,
        input  outData,
        input  outValid,
        output outReady
    );
endinterface

// File: rtl/regfile_dump_reader_counter.sv
// Register index walker: clearable up-counter that flags the last register and
// refuses to advance past it, so the walk never depends on wrap-around.
module dump_addr_counter #(
    parameter int ADDR_W = 5,
    parameter int LAST   = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] cnt,
    output logic              last
);
    logic [ADDR_W-1:0] cnt_r;
    logic              last_s;

    assign last_s = (cnt_r == ADDR_W'(LAST));

    // Index register: clear has priority, increment saturates at LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && !last_s) begin
            cnt_r <= cnt_r + ADDR_W'(1);
        end
    end

    assign cnt  = cnt_r;
    assign last = last_s;
endmodule

// File: rtl/regfile_dump_reader_reg.sv
// Plain enable register used to capture the presented word.
module dump_en_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_r;

    // Capture d whenever enabled, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
        end else if (en) begin
            q_r <= d;
        end
    end

    assign q = q_r;
endmodule

// File: rtl/regfile_dump_reader.sv
// Walks every architectural register through the shared read port and streams
// {address, data} out on a valid/ready link; used for debug and end-of-test dumps.
module regfile_dump_reader
    import regfile_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int ZERO_LAST = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    regfile_dump_reader_if.master bus
);
    dump_state_t       state_r;
    dump_state_t       next_state_s;
    logic              clr_s;
    logic              inc_s;
    logic              last_s;
    logic              accept_s;
    logic              capture_s;
    logic [ADDR_W-1:0] idx_s;
    logic [WIDTH-1:0]  cap_data_s;
    logic              out_valid_r;
    logic              busy_r;
    logic              done_r;

    // The index register doubles as the registered read address.
    dump_addr_counter #(
        .ADDR_W(ADDR_W),
        .LAST  (NUM_REGS - 1)
    ) u_idx (
        .clk  (clk),
        .rst_n(reset),
        .clr  (clr_s),
        .inc  (inc_s),
        .cnt  (idx_s),
        .last (last_s)
    );

    assign bus.rdAddr = idx_s;
    assign accept_s   = out_valid_r && bus.outReady;
    assign capture_s  = (state_r == FETCH);

    // Select the word to capture; the last register reads as zero when XZR masking is on.
    always_comb begin
        cap_data_s = bus.rdData;
        if ((ZERO_LAST != 0) && last_s) begin
            cap_data_s = '0;
        end else begin
            cap_data_s = bus.rdData;
        end
    end

    dump_en_reg #(.W(ADDR_W)) u_out_addr (
        .clk  (clk),
        .rst_n(reset),
        .en   (capture_s),
        .d    (idx_s),
        .q    (bus.outAddr)
    );

    dump_en_reg #(.W(WIDTH)) u_out_data (
        .clk  (clk),
        .rst_n(reset),
        .en   (capture_s),
        .d    (cap_data_s),
        .q    (bus.outData)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and counter control.
    always_comb begin
        next_state_s = state_r;
        clr_s        = 1'b0;
        inc_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    clr_s        = 1'b1;
                    next_state_s = FETCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: begin
                next_state_s = PRESENT;
            end
            PRESENT: begin
                if (accept_s && last_s) begin
                    next_state_s = DONE;
                end else if (accept_s) begin
                    inc_s        = 1'b1;
                    next_state_s = FETCH;
                end else begin
                    next_state_s = PRESENT;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            out_valid_r <= (next_state_s == PRESENT);
            busy_r      <= (next_state_s != IDLE);
            done_r      <= (next_state_s == DONE);
        end
    end

    assign bus.outValid = out_valid_r;
    assign busy         = busy_r;
    assign done         = done_r;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a queue of expected {addr, data} words
// per dump is checked against the output stream on every valid cycle.
module tb_regfile_dump_reader;
    import regfile_pkg::*;

    localparam int N = 32;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
    } word_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic ready0 = 1'b0;
    logic ready1 = 1'b0;
    logic busy0, done0, busy1, done1;
    logic [63:0] regs0 [N];
    logic [63:0] regs1 [N];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int accepted = 0;
    word_t exp_q[$];

    regfile_dump_reader_if #(.WIDTH(64), .ADDR_W(5)) bus0 ();
    regfile_dump_reader_if #(.WIDTH(64), .ADDR_W(5)) bus1 ();

    assign bus0.rdData   = regs0[bus0.rdAddr];
    assign bus0.outReady = ready0;
    assign bus1.rdData   = regs1[bus1.rdAddr];
    assign bus1.outReady = ready1;

    regfile_dump_reader #(.WIDTH(64), .NUM_REGS(N), .ADDR_W(5), .ZERO_LAST(1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0), .bus(bus0.master)
    );

    regfile_dump_reader #(.WIDTH(64), .NUM_REGS(N), .ADDR_W(5), .ZERO_LAST(0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .bus(bus1.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected content of register i as seen by the consumer.
    function automatic logic [63:0] model_data(input int i, input bit zl, input logic [63:0] v);
        return (zl && i == N - 1) ? 64'd0 : v;
    endfunction

    task automatic push_dump();
        word_t w;
        for (int i = 0; i < N; i++) begin
            w.addr = 5'(i);
            w.data = model_data(i, 1'b1, regs0[i]);
            exp_q.push_back(w);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_word(input int a, input string name);
        int k;
        k = 0;
        while (!(bus0.outValid && bus0.outAddr == 5'(a)) && k < 200) begin
            tick();
            k++;
        end
        chk(bus0.outValid && bus0.outAddr == 5'(a), name, 64'(bus0.outAddr), 64'(a));
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done0 && k < 300) begin
            tick();
            k++;
        end
        chk(done0 == 1'b1, name, 64'(done0), 64'd1);
    endtask

    // Stream checker: every valid word must equal the head of the expected queue.
    always @(negedge clk) begin
        if (reset) begin
            if (bus0.outValid) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_word", 64'(bus0.outAddr), 64'd0);
                end else begin
                    chk(bus0.outAddr == exp_q[0].addr, "word_addr", 64'(bus0.outAddr), 64'(exp_q[0].addr));
                    chk(bus0.outData == exp_q[0].data, "word_data", bus0.outData, exp_q[0].data);
                    if (ready0) begin
                        void'(exp_q.pop_front());
                        accepted++;
                    end
                end
            end
            if (done0) begin
                done_cnt++;
                chk(exp_q.size() == 0, "done_pending", 64'(exp_q.size()), 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, a0, d0, k;
        for (int i = 0; i < N; i++) begin
            regs0[i] = 64'(i * 3 + 1);
            regs1[i] = 64'(i * 3 + 1);
        end
        regs1[N-1] = 64'hDEAD_BEEF;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk(bus0.rdAddr == 5'd0, "rst_rdaddr", 64'(bus0.rdAddr), 64'd0);
        chk(bus0.outAddr == 5'd0, "rst_outaddr", 64'(bus0.outAddr), 64'd0);
        chk(bus0.outData == 64'd0, "rst_outdata", bus0.outData, 64'd0);
        chk(bus0.outValid == 1'b0, "rst_valid", 64'(bus0.outValid), 64'd0);
        chk(busy0 == 1'b0, "rst_busy", 64'(busy0), 64'd0);
        chk(done0 == 1'b0, "rst_done", 64'(done0), 64'd0);
        reset = 1'b1;
        tick();

        // Pin the model against hand values
        chk(model_data(7, 1'b1, regs0[7]) == 64'd22, "model_x7", model_data(7, 1'b1, regs0[7]), 64'd22);
        chk(model_data(30, 1'b1, regs0[30]) == 64'd91, "model_x30", model_data(30, 1'b1, regs0[30]), 64'd91);
        chk(model_data(31, 1'b1, regs0[31]) == 64'd0, "model_x31", model_data(31, 1'b1, regs0[31]), 64'd0);

        // Full dump with outReady tied high
        push_dump();
        ready0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        t0 = cyc;
        chk(bus0.outValid == 1'b0, "fetch_valid_low", 64'(bus0.outValid), 64'd0);
        chk(busy0 == 1'b1, "fetch_busy", 64'(busy0), 64'd1);
        chk(bus0.rdAddr == 5'd0, "fetch_rdaddr", 64'(bus0.rdAddr), 64'd0);
        tick();
        chk(bus0.outValid == 1'b1, "first_valid", 64'(bus0.outValid), 64'd1);
        chk(bus0.outAddr == 5'd0, "first_addr", 64'(bus0.outAddr), 64'd0);
        chk(bus0.outData == 64'd1, "first_data", bus0.outData, 64'd1);
        wait_done("dump1_done");
        chk(cyc - t0 == 64, "done_latency", 64'(cyc - t0), 64'd64);
        tick();
        chk(done0 == 1'b0, "done_one_cycle", 64'(done0), 64'd0);
        chk(busy0 == 1'b0, "idle_busy", 64'(busy0), 64'd0);
        chk(bus0.rdAddr == 5'd31, "rdaddr_left", 64'(bus0.rdAddr), 64'd31);
        chk(done_cnt == 1, "dump1_done_cnt", 64'(done_cnt), 64'd1);
        chk(accepted == 32, "dump1_words", 64'(accepted), 64'd32);

        // Backpressure at addr 7, ignored restart at addr 10
        push_dump();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_word(7, "reach_addr7");
        ready0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk(bus0.outValid == 1'b1, "stall_valid", 64'(bus0.outValid), 64'd1);
            chk(bus0.outAddr == 5'd7, "stall_addr", 64'(bus0.outAddr), 64'd7);
            chk(bus0.outData == 64'd22, "stall_data", bus0.outData, 64'd22);
        end
        ready0 = 1'b1;
        wait_word(10, "reach_addr10");
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done("dump2_done");
        tick();
        chk(done_cnt == 2, "dump2_done_cnt", 64'(done_cnt), 64'd2);
        chk(accepted == 64, "dump2_words", 64'(accepted), 64'd64);

        // Reset during PRESENT of addr 4
        push_dump();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_word(4, "reach_addr4");
        ready0 = 1'b0;
        tick();
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk(bus0.outValid == 1'b0, "rst_mid_valid", 64'(bus0.outValid), 64'd0);
        chk(busy0 == 1'b0, "rst_mid_busy", 64'(busy0), 64'd0);
        chk(bus0.rdAddr == 5'd0, "rst_mid_rdaddr", 64'(bus0.rdAddr), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk(busy0 == 1'b0, "post_rst_busy", 64'(busy0), 64'd0);
        chk(done_cnt == 2, "no_done_on_reset", 64'(done_cnt), 64'd2);
        ready0 = 1'b1;
        push_dump();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        chk(bus0.outValid == 1'b1, "restart_valid", 64'(bus0.outValid), 64'd1);
        chk(bus0.outAddr == 5'd0, "restart_addr0", 64'(bus0.outAddr), 64'd0);
        wait_done("dump3_done");
        tick();
        chk(done_cnt == 3, "dump3_done_cnt", 64'(done_cnt), 64'd3);

        // ZERO_LAST=0 instance passes X31 through
        ready1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        k = 0;
        while (!(bus1.outValid && bus1.outAddr == 5'd31) && k < 200) begin
            tick();
            k++;
        end
        chk(bus1.outAddr == 5'd31, "zl0_addr31", 64'(bus1.outAddr), 64'd31);
        chk(bus1.outData == 64'hDEAD_BEEF, "zl0_x31", bus1.outData, 64'hDEAD_BEEF);
        tick();
        chk(done1 == 1'b1, "zl0_done", 64'(done1), 64'd1);

        // Random backpressure full dump
        a0 = accepted;
        d0 = done_cnt;
        push_dump();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        k = 0;
        while (!done0 && k < 1000) begin
            ready0 = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk(done0 == 1'b1, "rand_done", 64'(done0), 64'd1);
        tick();
        chk(accepted - a0 == 32, "rand_words", 64'(accepted - a0), 64'd32);
        chk(done_cnt - d0 == 1, "rand_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk(exp_q.size() == 0, "rand_queue_empty", 64'(exp_q.size()), 64'd0);
        chk(busy0 == 1'b0, "rand_idle", 64'(busy0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
